pwm_fade_array: RTL and testbench

- Multi-channel PWM LED driver with a per-channel fade (ramp) engine. Generalises the fixed 3-channel RGB driver to CH channels.
- Software writes a target duty per channel through a valid/ready port. Each channel either jumps to the target or ramps toward it in fixed steps.
- Duty changes take effect only at PWM period boundaries, so no output pulse is ever truncated.

---
 rtl/pwm_fade_array.sv | 144 ++++++++++++++
 tb/tb_pwm_fade_array.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_array.sv
// Multi-channel PWM driver with per-channel fade engine; duty changes apply at period boundaries.
// Optional macro PWM_PHASE_STAGGER_EN staggers each channel's counter phase by c*(2^R/CH).
module pwm_fade_array #(
  parameter int CH       = 3,
  parameter int R        = 8,
  parameter int FADE_DIV = 4,
  parameter int STEP     = 1,
  parameter int CHW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           wr_valid_i,
  output logic           wr_ready_o,
  input  logic [CHW-1:0] wr_ch_i,
  input  logic [R:0]     wr_duty_i,
  input  logic           wr_fade_i,
  output logic [CH-1:0]  pwm_o,
  output logic [CH-1:0]  busy_o,
  output logic           period_o,
  output logic           probe_o
);

  localparam int DVW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [R-1:0] CNT_MAX = '1;
  localparam logic [R:0]   FULL    = {1'b1, {R{1'b0}}};

  logic [R-1:0]   cnt_q, cnt_d;
  logic [DVW-1:0] div_q, div_d;
  logic [R:0]     tgt_q [CH];
  logic [R:0]     tgt_d [CH];
  logic [R:0]     cur_q [CH];
  logic [R:0]     cur_d [CH];
  logic [CH-1:0]  fade_q, fade_d;
  logic [CH-1:0]  pwm_q, pwm_d;
  logic           period_q, period_d;
  logic           ready_q, ready_d;
  logic           boundary, fade_tick, wr_fire;
  logic [CH-1:0]  own_bnd, do_step;
`ifdef PWM_PHASE_STAGGER_EN
  logic [CH-1:0]  pend_q, pend_d;
  logic [R-1:0]   pc [CH];
`endif

  // Move cur toward tgt by STEP, landing exactly on tgt rather than overshooting.
  function automatic logic [R:0] step_toward(input logic [R:0] cur, input logic [R:0] tgt);
    logic [R+1:0] c2, t2, s2, n2;
    c2 = {1'b0, cur};
    t2 = {1'b0, tgt};
    s2 = (R+2)'(STEP);
    if (c2 < t2) begin
      n2 = c2 + s2;
      if (n2 > t2) n2 = t2;
    end else if (c2 > t2) begin
      n2 = (c2 < t2 + s2) ? t2 : c2 - s2;
    end else begin
      n2 = c2;
    end
    return (R+1)'(n2);
  endfunction

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    boundary  = (cnt_q == CNT_MAX);
    fade_tick = boundary && (div_q == DVW'(FADE_DIV - 1));
    div_d     = div_q;
    if (boundary) div_d = fade_tick ? '0 : div_q + 1'b1;
    period_d  = (cnt_d == CNT_MAX);
    ready_d   = (cnt_d != CNT_MAX);
    wr_fire   = wr_valid_i && ready_q;
    pwm_d     = '0;
    own_bnd   = '0;
    do_step   = '0;
    fade_d    = fade_q;
`ifdef PWM_PHASE_STAGGER_EN
    pend_d    = pend_q;
`endif
    for (int c = 0; c < CH; c++) begin
      tgt_d[c] = tgt_q[c];
      cur_d[c] = cur_q[c];
      if (wr_fire && (32'(wr_ch_i) == 32'(c))) begin
        tgt_d[c]  = (wr_duty_i > FULL) ? FULL : wr_duty_i;
        fade_d[c] = wr_fade_i;
      end
`ifdef PWM_PHASE_STAGGER_EN
      pc[c]      = cnt_q + R'(c * ((2 ** R) / CH));
      own_bnd[c] = (pc[c] == CNT_MAX);
      do_step[c] = pend_q[c] | fade_tick;
      pend_d[c]  = (pend_q[c] | fade_tick) & ~own_bnd[c];
      pwm_d[c]   = ({1'b0, pc[c]} < cur_q[c]);
      if ((cnt_d + R'(c * ((2 ** R) / CH))) == CNT_MAX) ready_d = 1'b0;
`else
      own_bnd[c] = boundary;
      do_step[c] = fade_tick;
      pwm_d[c]   = ({1'b0, cnt_q} < cur_q[c]);
`endif
      if (own_bnd[c]) begin
        if (!fade_q[c])      cur_d[c] = tgt_q[c];
        else if (do_step[c]) cur_d[c] = step_toward(cur_q[c], tgt_q[c]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q    <= '0;
      div_q    <= '0;
      fade_q   <= '0;
      pwm_q    <= '0;
      period_q <= 1'b0;
      ready_q  <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        tgt_q[c] <= '0;
        cur_q[c] <= '0;
      end
`ifdef PWM_PHASE_STAGGER_EN
      pend_q   <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      fade_q   <= fade_d;
      pwm_q    <= pwm_d;
      period_q <= period_d;
      ready_q  <= ready_d;
      for (int c = 0; c < CH; c++) begin
        tgt_q[c] <= tgt_d[c];
        cur_q[c] <= cur_d[c];
      end
`ifdef PWM_PHASE_STAGGER_EN
      pend_q   <= pend_d;
`endif
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++) busy_o[c] = (cur_q[c] != tgt_q[c]);
  end

  assign pwm_o      = pwm_q;
  assign period_o   = period_q;
  assign wr_ready_o = ready_q;
  assign probe_o    = pwm_q[0];

endmodule

// File: tb/tb_pwm_fade_array.sv
// Scoreboarded bench for pwm_fade_array: a period-level model predicts per-period pulse widths.
module tb_pwm_fade_array;
  localparam int CH   = 3;
  localparam int R    = 8;
  localparam int FD   = 2;
  localparam int STEP = 16;
  localparam int PER  = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_fade  = 1'b0;
  logic [1:0]    wr_ch    = '0;
  logic [R:0]    wr_duty  = '0;
  logic          wr_ready;
  logic [CH-1:0] pwm, busy;
  logic          period, probe;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_fade_array #(.CH(CH), .R(R), .FADE_DIV(FD), .STEP(STEP)) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_ch_i(wr_ch), .wr_duty_i(wr_duty), .wr_fade_i(wr_fade),
    .pwm_o(pwm), .busy_o(busy), .period_o(period), .probe_o(probe)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int approach(input int cur, input int tgt);
    if (cur < tgt) return (cur + STEP > tgt) ? tgt : cur + STEP;
    if (cur > tgt) return (cur - STEP < tgt) ? tgt : cur - STEP;
    return cur;
  endfunction

  // Reference model: state of the current clock cycle, advanced once per negedge.
  int m_cnt, m_div;
  int m_tgt[CH], m_cur[CH], m_fade[CH];
  bit m_ready, m_started, m_tick;
  int exp_q[$];

  always @(negedge clk) begin : model
    if (!rst) begin
      m_cnt = 0; m_div = 0; m_ready = 0; m_started = 0;
      exp_q.delete();
      for (int c = 0; c < CH; c++) begin
        m_tgt[c] = 0; m_cur[c] = 0; m_fade[c] = 0;
        exp_q.push_back(0);
      end
    end else begin
      if (m_started) begin
        if (m_cnt == PER - 1) begin
          m_tick = (m_div == FD - 1);
          for (int c = 0; c < CH; c++) begin
            if (m_fade[c] == 0) m_cur[c] = m_tgt[c];
            else if (m_tick)    m_cur[c] = approach(m_cur[c], m_tgt[c]);
            exp_q.push_back(m_cur[c]);
          end
          m_div = m_tick ? 0 : m_div + 1;
        end
        if (wr_valid && m_ready && (int'(wr_ch) < CH)) begin
          m_tgt[wr_ch]  = (int'(wr_duty) > PER) ? PER : int'(wr_duty);
          m_fade[wr_ch] = int'(wr_fade);
        end
        m_cnt   = (m_cnt + 1) % PER;
        m_ready = (m_cnt != PER - 1);
      end else begin
        m_started = 1;
      end
      check("period", int'(period), int'(m_cnt == PER - 1));
      check("ready", int'(wr_ready), int'(m_ready));
      check("probe", int'(probe), int'(pwm[0]));
      for (int c = 0; c < CH; c++)
        check($sformatf("busy%0d", c), int'(busy[c]), int'(m_cur[c] != m_tgt[c]));
    end
  end

  // Monitor: accumulate high clocks per period window and compare with the scoreboard.
  int acc[CH];
  bit per_d1;
  int e;

  always @(negedge clk) begin : monitor
    if (!rst) begin
      per_d1 = 0;
      for (int c = 0; c < CH; c++) acc[c] = 0;
    end else begin
      for (int c = 0; c < CH; c++) acc[c] += int'(pwm[c]);
      if (per_d1) begin
        if (exp_q.size() < CH) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty actual=%0d required=%0d", exp_q.size(), CH);
        end else begin
          for (int c = 0; c < CH; c++) begin
            e = exp_q.pop_front();
            check($sformatf("width_ch%0d", c), acc[c], e);
          end
        end
        for (int c = 0; c < CH; c++) acc[c] = 0;
      end
      per_d1 = period;
    end
  end

  task automatic wr(input int ch, input int duty, input bit fd);
    int n = 0;
    @(negedge clk); #1;
    wr_valid = 1'b1; wr_ch = ch[1:0]; wr_duty = duty[R:0]; wr_fade = fd;
    while (!wr_ready && n < 600) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 600) begin
      checks++; errors++;
      $display("FAIL wr_timeout actual=%0d required=<600", n);
    end
    @(negedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic run_periods(input int n);
    repeat (n * PER) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    wr(0, 64, 0);  run_periods(3);
    wr(2, 0, 0);   run_periods(2);
    wr(2, 256, 0); run_periods(2);
    wr(2, 300, 0); run_periods(2);
    wr(1, 64, 1);  run_periods(10);

    wr(1, 0, 0);   run_periods(2);
    wr(1, 128, 1);
    n = 0;
    while (m_cur[1] != 32 && n < 3000) begin @(negedge clk); #1; n++; end
    check("reach_cur32_cycles_ok", int'(n < 3000), 1);
    wr(1, 0, 1);   run_periods(6);

    n = 0;
    do begin @(negedge clk); #1; n++; end while (!period && n < 400);
    check("boundary_found", int'(period), 1);
    wr_valid = 1'b1; wr_ch = 2'd0; wr_duty = 9'd128; wr_fade = 1'b0;
    check("ready_at_boundary", int'(wr_ready), 0);
    @(negedge clk); #1;
    check("ready_after_boundary", int'(wr_ready), 1);
    @(negedge clk); #1;
    wr_valid = 1'b0;
    wr(3, 200, 0); run_periods(2);

    repeat (40) begin
      wr($urandom_range(0, 3), $urandom_range(0, 300), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 600)) @(negedge clk);
    end

    wr(1, 256, 1); run_periods(3);
    @(posedge clk); #3 rst = 1'b0;
    #1;
    check("rst_pwm", int'(pwm), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_period", int'(period), 0);
    check("rst_ready", int'(wr_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("ready_after_release", int'(wr_ready), 1);
    wr(2, 100, 1); run_periods(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
